// File: rtl/adder_gpio_ctrl.sv
// -----------------------------------------------------------------------------
// adder_gpio_ctrl
//
// Control stage that wraps the purely combinational signed Adder with a
// toggle handshake for software driving AXI-GPIO. A level change on
// gpio_req_tgl requests one addition. The operands are captured onto
// in_0/in_1. The Adder output is given one cycle to settle and is then
// sampled into gpio_result, and gpio_ack_tgl flips to report completion.
//
// Ports
//   clk           in   1       single clock for all logic
//   rst_n         in   1       asynchronous active-low reset
//   gpio_op_a     in   DATA_W  operand A from GPIO channel 1
//   gpio_op_b     in   DATA_W  operand B from GPIO channel 2
//   gpio_req_tgl  in   1       request; every level change = one operation
//   in_0          out  DATA_W  registered operand A to Adder
//   in_1          out  DATA_W  registered operand B to Adder
//   adder_out     in   DATA_W  combinational sum from Adder
//   gpio_result   out  DATA_W  registered result to GPIO
//   gpio_ack_tgl  out  1       toggles once per completed operation
//   gpio_busy     out  1       high from accept to completion
//   gpio_ovf      out  1       signed overflow of last operation
//   gpio_count    out  CNT_W   completed operations, wraps modulo 2^CNT_W
//
// Build option
//   ADDER_SAT_EN  defined: an overflowing result saturates to the most
//                 positive or most negative value. Undefined (default): the
//                 result wraps as two's complement. gpio_ovf is set either way.
// -----------------------------------------------------------------------------
module adder_gpio_ctrl #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] gpio_op_a,
    input  logic [DATA_W-1:0] gpio_op_b,
    input  logic              gpio_req_tgl,
    output logic [DATA_W-1:0] in_0,
    output logic [DATA_W-1:0] in_1,
    input  logic [DATA_W-1:0] adder_out,
    output logic [DATA_W-1:0] gpio_result,
    output logic              gpio_ack_tgl,
    output logic              gpio_busy,
    output logic              gpio_ovf,
    output logic [CNT_W-1:0]  gpio_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADD     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] req_sync_q;
    logic                   req_sync;
    logic                   req_seen;
    logic                   req_pend;
    logic                   ovf;
    logic [DATA_W-1:0]      result_nxt;

    // gpio_req_tgl comes from another clock domain, so it passes through a
    // flop chain before it is compared.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values and simulation order cannot change the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_sync_q <= '0;
        end else begin
            req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], gpio_req_tgl};
        end
    end

    assign req_sync = req_sync_q[SYNC_STAGES-1];

    // The pending flag holds one request only. A toggle that arrives while
    // busy is served on return to IDLE. Two toggles while busy cancel out.
    assign req_pend = (req_sync != req_seen);

    // Overflow is computed from the registered operands, which are the values
    // the Adder actually sees.
    assign ovf = (in_0[DATA_W-1] == in_1[DATA_W-1]) &&
                 (adder_out[DATA_W-1] != in_0[DATA_W-1]);

`ifdef ADDER_SAT_EN
    always_comb begin
        result_nxt = adder_out;
        if (ovf) begin
            result_nxt = in_0[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                        : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
`else
    assign result_nxt = adder_out;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets its default before the case statement, so every path
    // assigns it and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_pend) state_nxt = ADD;
            ADD:     state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The operand and status registers are updated by the FSM state. The
    // operands keep their values between operations, so the Adder output
    // stays stable while the block is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_0         <= '0;
            in_1         <= '0;
            req_seen     <= 1'b0;
            gpio_result  <= '0;
            gpio_ack_tgl <= 1'b0;
            gpio_busy    <= 1'b0;
            gpio_ovf     <= 1'b0;
            gpio_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_pend) begin
                        in_0      <= gpio_op_a;
                        in_1      <= gpio_op_b;
                        req_seen  <= req_sync;
                        gpio_busy <= 1'b1;
                    end
                end
                CAPTURE: begin
                    gpio_result  <= result_nxt;
                    gpio_ovf     <= ovf;
                    gpio_count   <= gpio_count + CNT_W'(1);
                    gpio_ack_tgl <= ~gpio_ack_tgl;
                    gpio_busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_gpio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adder_gpio_ctrl
//
// Directed testbench for adder_gpio_ctrl. The Adder is modelled as in_0+in_1.
// Inputs change on the falling edge of clk, and outputs are sampled on the
// falling edge.
//
// Expected timing, derived from a 2-flop synchroniser and the
// IDLE -> ADD -> CAPTURE sequence. The pin toggles at falling edge N0. The
// sync flops load at rising edges 1 and 2, the request is accepted at rising
// edge 3, and the result is captured at rising edge 5. The ack therefore
// changes at falling-edge sample 5. gpio_busy is high at samples 3 and 4.
// -----------------------------------------------------------------------------
module tb_adder_gpio_ctrl;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] gpio_op_a;
    logic [DATA_W-1:0] gpio_op_b;
    logic              gpio_req_tgl;
    logic [DATA_W-1:0] in_0;
    logic [DATA_W-1:0] in_1;
    logic [DATA_W-1:0] adder_out;
    logic [DATA_W-1:0] gpio_result;
    logic              gpio_ack_tgl;
    logic              gpio_busy;
    logic              gpio_ovf;
    logic [CNT_W-1:0]  gpio_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign adder_out = in_0 + in_1;

    adder_gpio_ctrl #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gpio_op_a    (gpio_op_a),
        .gpio_op_b    (gpio_op_b),
        .gpio_req_tgl (gpio_req_tgl),
        .in_0         (in_0),
        .in_1         (in_1),
        .adder_out    (adder_out),
        .gpio_result  (gpio_result),
        .gpio_ack_tgl (gpio_ack_tgl),
        .gpio_busy    (gpio_busy),
        .gpio_ovf     (gpio_ovf),
        .gpio_count   (gpio_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One operation: set operands, flip the request, then wait (bounded) for
    // the ack. The task reports the sample number of the ack and the number of
    // samples with busy high.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cyc);
        logic prev;
        @(negedge clk);
        gpio_op_a    = a;
        gpio_op_b    = b;
        prev         = gpio_ack_tgl;
        gpio_req_tgl = ~gpio_req_tgl;
        lat          = 0;
        busy_cyc     = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (gpio_busy) busy_cyc++;
            if (gpio_ack_tgl !== prev) begin
                lat = i;
                break;
            end
        end
        check("ack_seen", {31'd0, gpio_ack_tgl}, {31'd0, ~prev});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_0"},   in_0,                    32'd0);
        check({tag, "_in_1"},   in_1,                    32'd0);
        check({tag, "_result"}, gpio_result,             32'd0);
        check({tag, "_ack"},    {31'd0, gpio_ack_tgl},   32'd0);
        check({tag, "_busy"},   {31'd0, gpio_busy},      32'd0);
        check({tag, "_ovf"},    {31'd0, gpio_ovf},       32'd0);
        check({tag, "_count"},  {24'd0, gpio_count},     32'd0);
    endtask

    initial begin
        int   lat;
        int   busy_cyc;
        int   n_acks;
        logic prev;
        logic [31:0] a;
        logic [31:0] b;

        rst_n        = 1'b0;
        gpio_op_a    = '0;
        gpio_op_b    = '0;
        gpio_req_tgl = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Step 1: 5 + (-3).
        do_op(32'd5, 32'hFFFF_FFFD, lat, busy_cyc);
        check("op1_latency", lat,                   32'd5);
        check("op1_busy",    busy_cyc,              32'd2);
        check("op1_result",  gpio_result,           32'd2);
        check("op1_ovf",     {31'd0, gpio_ovf},     32'd0);
        check("op1_count",   {24'd0, gpio_count},   32'd1);
        check("op1_in_0",    in_0,                  32'd5);
        check("op1_in_1",    in_1,                  32'hFFFF_FFFD);

        // Step 2: positive overflow.
        do_op(32'h7FFF_FFFF, 32'd1, lat, busy_cyc);
        check("pos_ovf_flag", {31'd0, gpio_ovf}, 32'd1);
`ifdef ADDER_SAT_EN
        check("pos_ovf_result", gpio_result, 32'h7FFF_FFFF);
`else
        check("pos_ovf_result", gpio_result, 32'h8000_0000);
`endif
        check("pos_ovf_count", {24'd0, gpio_count}, 32'd2);

        // Step 3: negative overflow.
        do_op(32'h8000_0000, 32'hFFFF_FFFF, lat, busy_cyc);
        check("neg_ovf_flag", {31'd0, gpio_ovf}, 32'd1);
`ifdef ADDER_SAT_EN
        check("neg_ovf_result", gpio_result, 32'h8000_0000);
`else
        check("neg_ovf_result", gpio_result, 32'h7FFF_FFFF);
`endif
        check("neg_ovf_count", {24'd0, gpio_count}, 32'd3);

        // Step 4: a second toggle while busy. The operand change during busy
        // must not affect the first result. The second op is accepted in the
        // IDLE cycle right after the first CAPTURE, so its ack comes 3 samples
        // after the first ack.
        @(negedge clk);
        gpio_op_a    = 32'd1;
        gpio_op_b    = 32'd2;
        prev         = gpio_ack_tgl;
        gpio_req_tgl = ~gpio_req_tgl;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gpio_busy) break;
        end
        check("bt_busy_seen", {31'd0, gpio_busy}, 32'd1);
        gpio_op_a    = 32'd10;
        gpio_op_b    = 32'd20;
        gpio_req_tgl = ~gpio_req_tgl;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gpio_ack_tgl !== prev) break;
        end
        check("bt_ack1",    {31'd0, gpio_ack_tgl}, {31'd0, ~prev});
        check("bt_result1", gpio_result,           32'd3);
        check("bt_ovf1",    {31'd0, gpio_ovf},     32'd0);
        prev = gpio_ack_tgl;
        lat  = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (gpio_ack_tgl !== prev) begin
                lat = i;
                break;
            end
        end
        check("bt_ack2_gap", lat,                   32'd3);
        check("bt_result2",  gpio_result,           32'd30);
        check("bt_count",    {24'd0, gpio_count},   32'd5);
        repeat (10) @(negedge clk);
        check("bt_no_extra_ack", {31'd0, gpio_ack_tgl}, {31'd0, prev ^ 1'b1});

        // Step 5: reset during ADD. The outputs clear immediately and no ack
        // follows. The GPIO request pin also returns to 0 under reset.
        @(negedge clk);
        gpio_op_a    = 32'd7;
        gpio_op_b    = 32'd8;
        gpio_req_tgl = ~gpio_req_tgl;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gpio_busy) break;
        end
        check("mid_busy_seen", {31'd0, gpio_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_rst");
        gpio_req_tgl = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_reset_state("post_rst");

        // Step 6: 256 back-to-back ops. gpio_count wraps 255 -> 0.
        n_acks = 0;
        for (int i = 0; i < 256; i++) begin
            a = 32'(i) * 32'd1000;
            b = 32'd7 - 32'(i);
            do_op(a, b, lat, busy_cyc);
            if (lat > 0) n_acks++;
            check($sformatf("wrap_result_%0d", i), gpio_result, a + b);
            check($sformatf("wrap_count_%0d", i), {24'd0, gpio_count}, 32'((i + 1) % 256));
        end
        check("wrap_ack_total", n_acks, 32'd256);
        prev = gpio_ack_tgl;
        repeat (10) @(negedge clk);
        check("wrap_ack_quiet", {31'd0, gpio_ack_tgl}, {31'd0, prev});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
